// File: rtl/alu_md_unit.sv
// ALU control decode plus an iterative multiply/divide unit that owns HI/LO.
// Define ALU_MD_DIV_EN to build the restoring divider and the DIV state.
module alu_md_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       ALUop,
  input  logic [5:0]       func,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [2:0]       op,
  output logic             md_sel,
  output logic [WIDTH-1:0] md_result,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam int W2 = 2 * WIDTH;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
`ifdef ALU_MD_DIV_EN
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
`endif

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;   // partial product high half / partial remainder
  logic [WIDTH-1:0] mq;    // multiplier / dividend shifting into quotient
  logic [WIDTH-1:0] md;    // multiplicand / divisor magnitude
  logic             neg;   // product or quotient must be negated

  // ---- decode ----
  logic rtype, is_mul, is_div, is_mfhi, is_mflo, sgn;
  assign rtype   = (ALUop == 2'b10);
  assign is_mul  = rtype && (func == F_MULT || func == F_MULTU);
`ifdef ALU_MD_DIV_EN
  assign is_div  = rtype && (func == F_DIV || func == F_DIVU);
`else
  assign is_div  = 1'b0;
`endif
  assign is_mfhi = rtype && (func == F_MFHI);
  assign is_mflo = rtype && (func == F_MFLO);
  // mult and div both have func[0]=0 for the signed flavour
  assign sgn     = ~func[0];

  always_comb begin
    op = 3'b110;
    case (ALUop)
      2'b00: op = 3'b010;
      2'b01: op = 3'b110;
      2'b11: op = 3'b111;
      default: begin
        case (func)
          F_ADD:   op = 3'b010;
          F_SUB:   op = 3'b110;
          F_AND:   op = 3'b000;
          F_OR:    op = 3'b001;
          F_SLT:   op = 3'b111;
          F_MULT, F_MULTU, F_MFHI, F_MFLO: op = 3'b010;
`ifdef ALU_MD_DIV_EN
          F_DIV, F_DIVU: op = 3'b010;
`endif
          default: op = 3'b110;
        endcase
      end
    endcase
  end

  logic busy;
`ifdef ALU_MD_DIV_EN
  assign busy = (state == S_MUL) || (state == S_DIV);
`else
  assign busy = (state == S_MUL);
`endif

  assign stall     = rst_n && (busy || (state == S_IDLE && en && (is_mul || is_div)));
  assign md_sel    = en && (is_mfhi || is_mflo);
  assign md_result = is_mfhi ? hi : (is_mflo ? lo : '0);

  // ---- operand magnitudes ----
  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_mag = (sgn && a[WIDTH-1]) ? (WIDTH'(0) - a) : a;
  assign b_mag = (sgn && b[WIDTH-1]) ? (WIDTH'(0) - b) : b;

  // ---- shift-add multiply step ----
  logic [WIDTH:0]   msum;
  logic [WIDTH-1:0] mul_acc_n, mul_q_n;
  logic [W2-1:0]    prod, prod_fix;
  assign msum      = {1'b0, acc} + (mq[0] ? {1'b0, md} : '0);
  assign mul_acc_n = msum[WIDTH:1];
  assign mul_q_n   = {msum[0], mq[WIDTH-1:1]};
  assign prod      = {mul_acc_n, mul_q_n};
  assign prod_fix  = neg ? (W2'(0) - prod) : prod;

`ifdef ALU_MD_DIV_EN
  logic             neg_r;  // remainder follows dividend sign
  logic             dz;     // divisor was zero
  logic [WIDTH:0]   rsh;
  logic             ge;
  logic [WIDTH-1:0] dsub, div_acc_n, div_q_n, quo_fix, rem_fix;
  // restoring step: shift remainder left, keep the subtraction if it fits
  assign rsh       = {acc, mq[WIDTH-1]};
  assign ge        = (rsh >= {1'b0, md});
  assign dsub      = rsh[WIDTH-1:0] - md;
  assign div_acc_n = ge ? dsub : rsh[WIDTH-1:0];
  assign div_q_n   = {mq[WIDTH-2:0], ge};
  assign quo_fix   = dz ? '1 : (neg ? (WIDTH'(0) - div_q_n) : div_q_n);
  assign rem_fix   = neg_r ? (WIDTH'(0) - div_acc_n) : div_acc_n;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      acc   <= '0;
      mq    <= '0;
      md    <= '0;
      neg   <= 1'b0;
`ifdef ALU_MD_DIV_EN
      neg_r <= 1'b0;
      dz    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (en && (is_mul || is_div)) begin
            acc   <= '0;
            mq    <= a_mag;
            md    <= b_mag;
            neg   <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
            cnt   <= CW'(WIDTH - 1);
`ifdef ALU_MD_DIV_EN
            neg_r <= sgn && a[WIDTH-1];
            dz    <= (b == '0);
            state <= is_div ? S_DIV : S_MUL;
`else
            state <= S_MUL;
`endif
          end
        end
        S_MUL: begin
          acc <= mul_acc_n;
          mq  <= mul_q_n;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            hi    <= prod_fix[W2-1:WIDTH];
            lo    <= prod_fix[WIDTH-1:0];
            cnt   <= '0;
            state <= S_DONE;
          end
        end
`ifdef ALU_MD_DIV_EN
        S_DIV: begin
          acc <= div_acc_n;
          mq  <= div_q_n;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            hi    <= rem_fix;
            lo    <= quo_fix;
            cnt   <= '0;
            state <= S_DONE;
          end
        end
`endif
        // DONE lets the stalled instruction retire, so starts are ignored here
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_md_unit.sv
// Directed-vector bench for alu_md_unit (WIDTH=32); div tests follow ALU_MD_DIV_EN.
module tb_alu_md_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  ALUop;
  logic [5:0]  func;
  logic        en;
  logic [31:0] a, b;
  logic [2:0]  op;
  logic        md_sel;
  logic [31:0] md_result;
  logic        stall;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  alu_md_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .ALUop(ALUop), .func(func), .en(en),
    .a(a), .b(b), .op(op), .md_sel(md_sel), .md_result(md_result),
    .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // {ALUop, func, expected op}
  localparam logic [10:0] DEC_TBL [11] = '{
    {2'b00, 6'b100011, 3'b010},
    {2'b01, 6'b100000, 3'b110},
    {2'b11, 6'b000000, 3'b111},
    {2'b10, 6'b100000, 3'b010},
    {2'b10, 6'b100011, 3'b110},
    {2'b10, 6'b100100, 3'b000},
    {2'b10, 6'b100101, 3'b001},
    {2'b10, 6'b101010, 3'b111},
    {2'b10, 6'b011000, 3'b010},
    {2'b10, 6'b011001, 3'b010},
    {2'b10, 6'b000000, 3'b110}
  };

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an MD instruction and count cycles until stall drops (DONE).
  task automatic run_md(input logic [5:0] f, input logic [31:0] av, input logic [31:0] bv,
                        output int n);
    ALUop = 2'b10; func = f; a = av; b = bv; en = 1'b1;
    #1;
    n = 0;
    while (stall === 1'b1 && n < 100) begin
      n++;
      tick();
    end
  endtask

  task automatic retire();
    en = 1'b0; ALUop = 2'b00; func = 6'b0;
    tick();
  endtask

  task automatic chk_md(input string name, input logic [5:0] f, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    run_md(f, av, bv, n);
    checks++;
    if (n !== 33) begin errors++; $display("FAIL %s stall_cycles got %0d want 33", name, n); end
    checks++;
    if (hi !== ehi) begin errors++; $display("FAIL %s hi got %h want %h", name, hi, ehi); end
    checks++;
    if (lo !== elo) begin errors++; $display("FAIL %s lo got %h want %h", name, lo, elo); end
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL %s done_stall got %b want 0", name, stall); end
    retire();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; ALUop = 2'b00; func = 6'b0; a = '0; b = '0;
    tick(); tick();
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
    checks++;
    if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
    checks++;
    if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_decode();
    logic [10:0] v;
    en = 1'b0;
    for (int i = 0; i < 11; i++) begin
      v = DEC_TBL[i];
      ALUop = v[10:9]; func = v[8:3];
      #1;
      checks++;
      if (op !== v[2:0]) begin
        errors++;
        $display("FAIL decode[%0d] ALUop=%b func=%b op got %b want %b", i, v[10:9], v[8:3], op, v[2:0]);
      end
    end
    ALUop = 2'b00; func = 6'b0;
    tick();
  endtask

  task automatic test_mult();
    chk_md("mult_7x-3",   6'b011000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB);
    chk_md("mult_-5x-6",  6'b011000, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'h00000000, 32'd30);
    chk_md("mult_minsq",  6'b011000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    // mflo in IDLE returns current LO
    ALUop = 2'b10; func = 6'b010010; en = 1'b1;
    #1;
    checks++;
    if (md_sel !== 1'b1 || md_result !== 32'h0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL mflo_idle sel=%b res=%h stall=%b want 1 00000000 0", md_sel, md_result, stall);
    end
    retire();
  endtask

  task automatic test_mfhi_busy();
    int n = 0;
    bit selbad = 0;
    ALUop = 2'b10; func = 6'b011001; a = 32'h00010000; b = 32'h00010000; en = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL mfhi_busy start_stall got %b want 1", stall); end
    tick();
    func = 6'b010000;
    #1;
    while (stall === 1'b1 && n < 100) begin
      if (md_sel !== 1'b1) selbad = 1;
      n++;
      tick();
    end
    checks++;
    if (n !== 32) begin errors++; $display("FAIL mfhi_busy stall_cycles got %0d want 32", n); end
    checks++;
    if (selbad) begin errors++; $display("FAIL mfhi_busy md_sel got 0 want 1 while busy"); end
    checks++;
    if (md_sel !== 1'b1 || md_result !== 32'h1) begin
      errors++;
      $display("FAIL mfhi_done sel=%b res=%h want 1 00000001", md_sel, md_result);
    end
    checks++;
    if (lo !== 32'h0) begin errors++; $display("FAIL mfhi_done lo got %h want 0", lo); end
    retire();
  endtask

  task automatic test_reset_mid();
    ALUop = 2'b10; func = 6'b011001; a = 32'h12345; b = 32'h777; en = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if (stall !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid stall=%b hi=%h lo=%h want 0 0 0", stall, hi, lo);
    end
    rst_n = 1'b1; en = 1'b0;
    tick();
    checks++;
    if (stall !== 1'b0 || hi !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_idle stall=%b hi=%h want 0 0", stall, hi);
    end
    chk_md("multu_max", 6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
  endtask

`ifdef ALU_MD_DIV_EN
  task automatic test_div();
    chk_md("divu_100_7",  6'b011011, 32'd100,      32'd7,        32'h00000002, 32'h0000000E);
    chk_md("div_-7_2",    6'b011010, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    chk_md("div_by0",     6'b011010, 32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF);
    chk_md("div_min_m1",  6'b011010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
  endtask
`else
  task automatic test_nodiv();
    ALUop = 2'b10; func = 6'b011011; a = 32'd100; b = 32'd7; en = 1'b1;
    #1;
    checks++;
    if (op !== 3'b110) begin errors++; $display("FAIL nodiv_op got %b want 110", op); end
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL nodiv_stall got %b want 0", stall); end
    for (int i = 0; i < 40; i++) tick();
    checks++;
    if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001 || stall !== 1'b0) begin
      errors++;
      $display("FAIL nodiv_hilo hi=%h lo=%h stall=%b want fffffffe 00000001 0", hi, lo, stall);
    end
    retire();
  endtask
`endif

  initial begin
    test_reset();
    test_decode();
    test_mult();
    test_mfhi_busy();
    test_reset_mid();
`ifdef ALU_MD_DIV_EN
    test_div();
`else
    test_nodiv();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
